x86_mem_arbiter: RTL and testbench

Shares the single byte-wide memory port between the x86cpu core and one DMA/video requester. Drives the core's `locked` step-enable so that each core bus cycle advances only when its memory access has completed. Arbitrates round-robin, sequences memory address, write and read-latency timing, and returns read data to the winner. Sits between x86cpu, the DMA engine and the on-chip RAM.

---
 rtl/x86_bus_pkg.sv | 21 ++
 rtl/x86_mem_arbiter.sv | 118 +++++++++++
 tb/tb_x86_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/x86_bus_pkg.sv
// Shared types and constants for the x86 memory bus: state encoding, owner ids, default width.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package x86_bus_pkg;

  // Default physical address width of the x86 bus.
  localparam int X86_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/x86_mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide RAM port between the x86 core and a DMA/video requester.
// Latency: grant -> completion pulse in MEM_LAT+2 cycles; one access every MEM_LAT+3 cycles.
// Backpressure: requesters hold their request until cpu_locked/dma_ack; the core is stalled by withholding cpu_locked.
//
// Ports:
//   clock, reset_n                 : clock and async active-low reset
//   cpu_req/address/o_data/wr      : core bus cycle request
//   cpu_locked, cpu_i_data         : core step-enable pulse and registered read data
//   dma_req/addr/we/wdata          : DMA request (level, held until ack)
//   dma_ack, dma_rdata             : DMA completion pulse and registered read data
//   mem_addr/we/wdata, mem_q       : RAM port, read data valid MEM_LAT cycles after address
module x86_mem_arbiter
  import x86_bus_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = X86_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_o_data,
  input  logic              cpu_wr,
  output logic              cpu_locked,
  output logic [7:0]        cpu_i_data,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_q
);

  state_t     state;
  state_t     state_nxt;
  owner_t     owner;
  owner_t     last;
  logic [2:0] cnt;
  logic       is_wr;
  logic       pick_dma;
  logic       last_wait;

  // Round-robin: DMA wins when it is the only requester, or when both request and the core was served last.
  assign pick_dma  = dma_req & (~cpu_req | (last == OWN_CPU));
  assign last_wait = (state == WAIT) && (cnt == 3'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req || dma_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (cnt == 3'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= OWN_CPU;
      last       <= OWN_DMA;
      cnt        <= 3'd0;
      is_wr      <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= 8'h00;
      cpu_locked <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_i_data <= 8'h00;
      dma_rdata  <= 8'h00;
    end else begin
      // Completion pulses are set on entry to DONE, so they are exactly one cycle wide.
      cpu_locked <= last_wait && (owner == OWN_CPU);
      dma_ack    <= last_wait && (owner == OWN_DMA);

      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner     <= pick_dma ? OWN_DMA : OWN_CPU;
            mem_addr  <= pick_dma ? dma_addr : cpu_address;
            mem_we    <= pick_dma ? dma_we : cpu_wr;
            is_wr     <= pick_dma ? dma_we : cpu_wr;
            mem_wdata <= pick_dma ? dma_wdata : cpu_o_data;
          end
        end
        ACCESS: begin
          cnt    <= 3'(MEM_LAT);
          mem_we <= 1'b0;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          // mem_q is valid on the last WAIT cycle; writes leave the read registers untouched.
          if (cnt == 3'd1 && !is_wr) begin
            if (owner == OWN_DMA) dma_rdata  <= mem_q;
            else                  cpu_i_data <= mem_q;
          end
        end
        DONE: begin
          last <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x86_mem_arbiter.sv
module tb_x86_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n, rst2_n;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  // DUT1: MEM_LAT=1
  logic        cpu_req, cpu_wr, cpu_locked, dma_req, dma_we, dma_ack, mem_we;
  logic [19:0] cpu_address, dma_addr, mem_addr;
  logic [7:0]  cpu_o_data, cpu_i_data, dma_wdata, dma_rdata, mem_wdata, mem_q;

  // DUT2: MEM_LAT=3, core only
  logic        cpu2_req, cpu2_locked, dma2_ack, mem2_we;
  logic [19:0] cpu2_address, mem2_addr;
  logic [7:0]  cpu2_i_data, dma2_rdata, mem2_wdata, mem2_q;
  logic        tie0 = 1'b0;
  logic [19:0] tie_a = 20'h0;
  logic [7:0]  tie_d = 8'h00;

  x86_mem_arbiter #(.MEM_LAT(1), .ADDR_W(20)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_o_data(cpu_o_data), .cpu_wr(cpu_wr),
    .cpu_locked(cpu_locked), .cpu_i_data(cpu_i_data),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_q(mem_q)
  );

  x86_mem_arbiter #(.MEM_LAT(3), .ADDR_W(20)) dut2 (
    .clock(clock), .reset_n(rst2_n),
    .cpu_req(cpu2_req), .cpu_address(cpu2_address), .cpu_o_data(tie_d), .cpu_wr(tie0),
    .cpu_locked(cpu2_locked), .cpu_i_data(cpu2_i_data),
    .dma_req(tie0), .dma_addr(tie_a), .dma_we(tie0), .dma_wdata(tie_d),
    .dma_ack(dma2_ack), .dma_rdata(dma2_rdata),
    .mem_addr(mem2_addr), .mem_we(mem2_we), .mem_wdata(mem2_wdata), .mem_q(mem2_q)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: fixed content pattern, read latency 1 (DUT1) and 3 (DUT2) from address.
  function automatic logic [7:0] pat(input logic [19:0] a);
    if (a == 20'hFFFF0) return 8'hEA;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  logic [7:0] p1 = 8'h00;
  logic [7:0] p2a = 8'h00, p2b = 8'h00, p2c = 8'h00;
  always @(posedge clock) begin
    p1  <= pat(mem_addr);
    p2a <= pat(mem2_addr);
    p2b <= p2a;
    p2c <= p2b;
  end
  assign mem_q  = p1;
  assign mem2_q = p2c;

  typedef struct { bit is_dma; logic [7:0] data; int cyc; } ev_t;
  typedef struct { logic [19:0] addr; logic [7:0] data; int cyc; } wr_t;
  ev_t exp_q[$];
  wr_t wr_q[$];
  ev_t exp2_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit d, input logic [7:0] v, input int c);
    ev_t e;
    e.is_dma = d; e.data = v; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [19:0] a, input logic [7:0] v, input int c);
    wr_t w;
    w.addr = a; w.data = v; w.cyc = c;
    wr_q.push_back(w);
  endtask

  task automatic push_ev2(input logic [7:0] v, input int c);
    ev_t e;
    e.is_dma = 1'b0; e.data = v; e.cyc = c;
    exp2_q.push_back(e);
  endtask

  // Monitors: compare every completion pulse and every write strobe against the scoreboard.
  always @(negedge clock) begin
    if (cpu_locked || dma_ack) begin
      chk("pulse_exclusive", {31'd0, cpu_locked & dma_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: cpu_locked=%0b dma_ack=%0b with no access pending (cycle %0d)",
                 cpu_locked, dma_ack, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_owner", {31'd0, dma_ack}, {31'd0, e.is_dma});
        chk("pulse_cycle", cyc, e.cyc);
        chk("read_data", {24'd0, (e.is_dma ? dma_rdata : cpu_i_data)}, {24'd0, e.data});
      end
    end
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: mem_we=1 addr=%0h (cycle %0d)", mem_addr, cyc);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", {12'd0, mem_addr}, {12'd0, w.addr});
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, w.data});
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (cpu2_locked || dma2_ack || mem2_we) begin
      if (exp2_q.size() == 0 || dma2_ack || mem2_we) begin
        checks++; errors++;
        $display("FAIL unexpected_dut2_event: locked=%0b ack=%0b we=%0b (cycle %0d)",
                 cpu2_locked, dma2_ack, mem2_we, cyc);
      end else begin
        ev_t e;
        e = exp2_q.pop_front();
        chk("lat3_cycle", cyc, e.cyc);
        chk("lat3_data", {24'd0, cpu2_i_data}, {24'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cpu_locked"}, {31'd0, cpu_locked}, 32'd0);
    chk({tag, "_cpu_i_data"}, {24'd0, cpu_i_data}, 32'd0);
    chk({tag, "_dma_ack"},    {31'd0, dma_ack}, 32'd0);
    chk({tag, "_dma_rdata"},  {24'd0, dma_rdata}, 32'd0);
    chk({tag, "_mem_addr"},   {12'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_we"},     {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_wdata"},  {24'd0, mem_wdata}, 32'd0);
  endtask

  initial begin
    int t;
    reset_n = 1'b0; rst2_n = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_address = '0; cpu_o_data = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    cpu2_req = 1'b0; cpu2_address = '0;

    // Reset values
    repeat (3) tick();
    @(negedge clock);
    chk_zero("reset");

    // Lone core read of 0xFFFF0, back-to-back every 4 cycles
    tick();
    t = cyc;
    reset_n = 1'b1; cpu_req = 1'b1; cpu_address = 20'hFFFF0; cpu_wr = 1'b0;
    push_ev(0, 8'hEA, t + 3);
    push_ev(0, 8'hEA, t + 7);
    push_ev(0, 8'hEA, t + 11);
    wait_cyc(t + 1);
    @(negedge clock);
    chk("access_mem_addr", {12'd0, mem_addr}, 32'hFFFF0);
    chk("access_read_we", {31'd0, mem_we}, 32'd0);
    wait_cyc(t + 9);
    cpu_req = 1'b0;
    wait_cyc(t + 12);

    // Both requesting: last served was core, so DMA first, then alternate
    t = cyc;
    cpu_req = 1'b1; cpu_address = 20'h12345;
    dma_req = 1'b1; dma_addr = 20'h00ABC; dma_we = 1'b0;
    push_ev(1, 8'h8A, t + 3);
    push_ev(0, 8'h5A, t + 7);
    push_ev(1, 8'h8A, t + 11);
    push_ev(0, 8'h5A, t + 15);
    wait_cyc(t + 13);
    cpu_req = 1'b0; dma_req = 1'b0;
    wait_cyc(t + 16);

    // DMA write, dropping dma_req right after grant; read data must be kept
    t = cyc;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 20'h00400; dma_wdata = 8'h5A;
    push_wr(20'h00400, 8'h5A, t + 1);
    push_ev(1, 8'h8A, t + 3);
    wait_cyc(t + 1);
    dma_req = 1'b0; dma_we = 1'b0;
    wait_cyc(t + 4);

    // Core write
    t = cyc;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_address = 20'h00020; cpu_o_data = 8'h77;
    push_wr(20'h00020, 8'h77, t + 1);
    push_ev(0, 8'h5A, t + 3);
    wait_cyc(t + 1);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    wait_cyc(t + 4);

    // One-cycle dma_req during core WAIT: withdrawn, never granted
    t = cyc;
    cpu_req = 1'b1; cpu_address = 20'h00031;
    push_ev(0, 8'h0D, t + 3);
    wait_cyc(t + 1);
    cpu_req = 1'b0;
    wait_cyc(t + 2);
    dma_req = 1'b1; dma_addr = 20'h00777; dma_we = 1'b0;
    wait_cyc(t + 3);
    dma_req = 1'b0;
    wait_cyc(t + 6);

    // Reset during WAIT of a DMA read: access abandoned, outputs clear at once
    t = cyc;
    dma_req = 1'b1; dma_addr = 20'h00555; dma_we = 1'b0;
    wait_cyc(t + 1);
    dma_req = 1'b0;
    @(negedge clock);
    chk("dma_access_addr", {12'd0, mem_addr}, 32'h00555);
    wait_cyc(t + 2);
    reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    wait_cyc(t + 4);

    // After release with both requesting, the core is granted first
    t = cyc;
    reset_n = 1'b1;
    cpu_req = 1'b1; cpu_address = 20'h00666;
    dma_req = 1'b1; dma_addr = 20'h00555;
    push_ev(0, 8'h5C, t + 3);
    push_ev(1, 8'h6C, t + 7);
    wait_cyc(t + 5);
    cpu_req = 1'b0; dma_req = 1'b0;
    wait_cyc(t + 10);

    // MEM_LAT=3 instance: WAIT spans 3 cycles, pulse 5 cycles after grant
    @(negedge clock);
    chk("lat3_reset_addr", {12'd0, mem2_addr}, 32'd0);
    chk("lat3_reset_data", {24'd0, cpu2_i_data}, 32'd0);
    tick();
    t = cyc;
    rst2_n = 1'b1; cpu2_req = 1'b1; cpu2_address = 20'h0ABCD;
    push_ev2(8'h5A, t + 5);
    wait_cyc(t + 1);
    cpu2_req = 1'b0;
    wait_cyc(t + 6);
    t = cyc;
    cpu2_req = 1'b1; cpu2_address = 20'h00F00;
    push_ev2(8'h33, t + 5);
    wait_cyc(t + 1);
    cpu2_req = 1'b0;
    wait_cyc(t + 8);

    @(negedge clock);
    chk("pending_pulses", exp_q.size(), 32'd0);
    chk("pending_writes", wr_q.size(), 32'd0);
    chk("pending_lat3", exp2_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
